// File: rtl/arm_imm_encoder_if.sv
// arm_imm_encoder_if: request/result bundle for the ARM immediate encoder.
//   start      request, sampled only while the encoder is idle
//   value      32-bit constant to encode, captured with an accepted start
//   busy       search in progress
//   done       one-cycle completion pulse
//   encodable  a representation was found (valid with done, then held)
//   invert     the representation encodes ~value (valid with done, then held)
//   imm12      {rotate[3:0], imm8[7:0]} (valid with done, then held)
// master drives requests (stimulus / IR builder); slave is the encoder.
interface arm_imm_encoder_if;
    logic        start;
    logic [31:0] value;
    logic        busy;
    logic        done;
    logic        encodable;
    logic        invert;
    logic [11:0] imm12;

    modport master (
        output start,
        output value,
        input  busy,
        input  done,
        input  encodable,
        input  invert,
        input  imm12
    );

    modport slave (
        input  start,
        input  value,
        output busy,
        output done,
        output encodable,
        output invert,
        output imm12
    );
endinterface

// File: rtl/arm_imm_encoder.sv
// arm_imm_encoder: multi-cycle search for the ARM data-processing immediate
// {rotate, imm8} with value == ROR(imm8, 2*rotate). One candidate per clock:
// candidates 0..15 try the captured operand at rotate 0..15, candidates
// 16..31 try its complement (MVN/BIC substitution). First hit wins, so the
// plain form beats the inverted one and the lowest rotation is preferred.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    arm_imm_encoder_if.slave (start/value in, busy/done/results out)
module arm_imm_encoder (
    input  logic                  clk,
    input  logic                  reset,
    arm_imm_encoder_if.slave      bus
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned ROT_W  = 4;
    localparam int unsigned IMM8_W = 8;
    localparam int unsigned IMM_W  = ROT_W + IMM8_W;
    localparam int unsigned SH_W   = 6;

    typedef enum logic {
        IDLE   = 1'b0,
        SEARCH = 1'b1
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   op;
    logic [IDX_W-1:0]    idx;
    logic                busy_q;
    logic                done_q;
    logic                encodable_q;
    logic                invert_q;
    logic [IMM_W-1:0]    imm12_q;

    // Candidate evaluation for the current idx
    logic [DATA_W-1:0]   cand_x_c;
    logic [SH_W-1:0]     cand_sh_c;
    logic [2*DATA_W-1:0] cand_dbl_c;
    logic [DATA_W-1:0]   cand_t_c;
    logic                cand_hit_c;
    logic [ROT_W-1:0]    cand_rot_c;
    logic [IMM8_W-1:0]   cand_imm8_c;
    logic                last_c;

    // Hit test: rotate the candidate left by 2r; it fits iff only the low byte survives.
    always_comb begin
        cand_x_c    = idx[IDX_W-1] ? ~op : op;
        cand_rot_c  = idx[ROT_W-1:0];
        cand_sh_c   = {1'b0, cand_rot_c, 1'b0};
        // Doubling the word makes the left shift behave as a wrap-around rotate.
        cand_dbl_c  = {cand_x_c, cand_x_c} << cand_sh_c;
        cand_t_c    = cand_dbl_c[2*DATA_W-1:DATA_W];
        cand_hit_c  = (cand_t_c[DATA_W-1:IMM8_W] == (DATA_W-IMM8_W)'(0));
        cand_imm8_c = cand_t_c[IMM8_W-1:0];
        last_c      = (idx == IDX_W'(31));
    end

    // Control FSM with registered handshake and result outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            op          <= '0;
            idx         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            encodable_q <= 1'b0;
            invert_q    <= 1'b0;
            imm12_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op          <= bus.value;
                        idx         <= '0;
                        busy_q      <= 1'b1;
                        encodable_q <= 1'b0;
                        invert_q    <= 1'b0;
                        imm12_q     <= '0;
                        state       <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cand_hit_c) begin
                        encodable_q <= 1'b1;
                        invert_q    <= idx[IDX_W-1];
                        imm12_q     <= {cand_rot_c, cand_imm8_c};
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else if (last_c) begin
                        encodable_q <= 1'b0;
                        invert_q    <= 1'b0;
                        imm12_q     <= '0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.encodable = encodable_q;
    assign bus.invert    = invert_q;
    assign bus.imm12     = imm12_q;

endmodule

// File: tb/tb_arm_imm_encoder.sv
// tb_arm_imm_encoder: directed tests for arm_imm_encoder with hand-computed
// latencies and encodings.
module tb_arm_imm_encoder;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    arm_imm_encoder_if bus ();

    arm_imm_encoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one request and count cycles until done (-1 if it never comes).
    task automatic run(input logic [31:0] v, output int lat);
        @(negedge clk);
        bus.value = v;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.value = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.encodable, bus.invert, bus.imm12} !== 16'h0000) begin
            $display("FAIL reset_outputs got busy=%b done=%b enc=%b inv=%b imm=%h want all 0",
                     bus.busy, bus.done, bus.encodable, bus.invert, bus.imm12);
            fails++;
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int lat;
        run(32'h000000FF, lat);
        tests++;
        if (lat !== 1) begin
            $display("FAIL ff_latency got %0d want 1", lat); fails++;
        end
        tests++;
        if ({bus.encodable, bus.invert, bus.imm12, bus.busy} !== {1'b1, 1'b0, 12'h0FF, 1'b0}) begin
            $display("FAIL ff_result got enc=%b inv=%b imm=%h busy=%b want 1 0 0ff 0",
                     bus.encodable, bus.invert, bus.imm12, bus.busy); fails++;
        end
        run(32'h00000000, lat);
        tests++;
        if (lat !== 1 || {bus.encodable, bus.invert, bus.imm12} !== {1'b1, 1'b0, 12'h000}) begin
            $display("FAIL zero got lat=%0d enc=%b inv=%b imm=%h want 1 1 0 000",
                     lat, bus.encodable, bus.invert, bus.imm12); fails++;
        end
    endtask

    task automatic test_rotation();
        int lat;
        run(32'hFF000000, lat);
        tests++;
        if (lat !== 5 || {bus.encodable, bus.invert, bus.imm12} !== {1'b1, 1'b0, 12'h4FF}) begin
            $display("FAIL rot_ff000000 got lat=%0d enc=%b inv=%b imm=%h want 5 1 0 4ff",
                     lat, bus.encodable, bus.invert, bus.imm12); fails++;
        end
        // Results hold after done
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({bus.done, bus.busy, bus.encodable, bus.imm12} !== {1'b0, 1'b0, 1'b1, 12'h4FF}) begin
            $display("FAIL hold got done=%b busy=%b enc=%b imm=%h want 0 0 1 4ff",
                     bus.done, bus.busy, bus.encodable, bus.imm12); fails++;
        end
        run(32'hF000000F, lat);
        tests++;
        if (lat !== 3 || bus.imm12 !== 12'h2FF || bus.encodable !== 1'b1) begin
            $display("FAIL rot_wrap got lat=%0d enc=%b imm=%h want 3 1 2ff",
                     lat, bus.encodable, bus.imm12); fails++;
        end
        run(32'h000003FC, lat);
        tests++;
        if (lat !== 16 || bus.imm12 !== 12'hFFF || bus.invert !== 1'b0) begin
            $display("FAIL rot_max got lat=%0d inv=%b imm=%h want 16 0 fff",
                     lat, bus.invert, bus.imm12); fails++;
        end
    endtask

    task automatic test_invert();
        int lat;
        run(32'hFFFFFFFF, lat);
        tests++;
        if (lat !== 17 || {bus.encodable, bus.invert, bus.imm12} !== {1'b1, 1'b1, 12'h000}) begin
            $display("FAIL inv_ones got lat=%0d enc=%b inv=%b imm=%h want 17 1 1 000",
                     lat, bus.encodable, bus.invert, bus.imm12); fails++;
        end
        run(32'hFFFFFF00, lat);
        tests++;
        if (lat !== 17 || {bus.encodable, bus.invert, bus.imm12} !== {1'b1, 1'b1, 12'h0FF}) begin
            $display("FAIL inv_ff00 got lat=%0d enc=%b inv=%b imm=%h want 17 1 1 0ff",
                     lat, bus.encodable, bus.invert, bus.imm12); fails++;
        end
    endtask

    task automatic test_no_hit();
        int lat;
        int bad;
        @(negedge clk);
        bus.value = 32'h00000101;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        tests++;
        if (bus.encodable !== 1'b0 || bus.imm12 !== 12'h000) begin
            $display("FAIL start_clear got enc=%b imm=%h want 0 000", bus.encodable, bus.imm12);
            fails++;
        end
        lat = -1;
        bad = 0;
        for (int n = 1; n <= 40; n++) begin
            // Mid-search start with a trivially encodable value must be ignored
            if (n == 5) begin
                bus.value = 32'h000000FF;
                bus.start = 1'b1;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (bus.busy !== 1'b1) bad++;
        end
        bus.start = 1'b0;
        tests++;
        if (lat !== 32 || {bus.encodable, bus.invert, bus.imm12, bus.busy} !== 15'h0) begin
            $display("FAIL no_hit got lat=%0d enc=%b inv=%b imm=%h busy=%b want 32 0 0 000 0",
                     lat, bus.encodable, bus.invert, bus.imm12, bus.busy); fails++;
        end
        tests++;
        if (bad !== 0) begin
            $display("FAIL busy_during_search got %0d low cycles want 0", bad); fails++;
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run(32'hFF000000, lat);
        tests++;
        if (lat !== 5) begin
            $display("FAIL b2b_first got lat=%0d want 5", lat); fails++;
        end
        // Still in the done cycle: request again
        bus.value = 32'h000000FF;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        tests++;
        if ({bus.busy, bus.done, bus.encodable, bus.imm12} !== {1'b1, 1'b0, 1'b0, 12'h000}) begin
            $display("FAIL b2b_accept got busy=%b done=%b enc=%b imm=%h want 1 0 0 000",
                     bus.busy, bus.done, bus.encodable, bus.imm12); fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if ({bus.done, bus.busy, bus.encodable, bus.imm12} !== {1'b1, 1'b0, 1'b1, 12'h0FF}) begin
            $display("FAIL b2b_second got done=%b busy=%b enc=%b imm=%h want 1 0 1 0ff",
                     bus.done, bus.busy, bus.encodable, bus.imm12); fails++;
        end
        @(posedge clk);
        #1;
        tests++;
        if (bus.done !== 1'b0) begin
            $display("FAIL done_width got done=%b want 0", bus.done); fails++;
        end
    endtask

    task automatic test_reset_abort();
        int lat;
        int seen;
        @(negedge clk);
        bus.value = 32'h00000101;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        tests++;
        if ({bus.busy, bus.done, bus.encodable, bus.invert, bus.imm12} !== 16'h0000) begin
            $display("FAIL abort_outputs got busy=%b done=%b enc=%b inv=%b imm=%h want all 0",
                     bus.busy, bus.done, bus.encodable, bus.invert, bus.imm12); fails++;
        end
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen++;
        end
        tests++;
        if (seen !== 0) begin
            $display("FAIL abort_quiet got %0d active cycles want 0", seen); fails++;
        end
        run(32'h000000FF, lat);
        tests++;
        if (lat !== 1 || {bus.encodable, bus.invert, bus.imm12} !== {1'b1, 1'b0, 12'h0FF}) begin
            $display("FAIL after_abort got lat=%0d enc=%b inv=%b imm=%h want 1 1 0 0ff",
                     lat, bus.encodable, bus.invert, bus.imm12); fails++;
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        test_reset();
        test_basic();
        test_rotation();
        test_invert();
        test_no_hit();
        test_back_to_back();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
